// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// encoding and operand-sign helpers used by the execute-stage decode.
package mdu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] MDU_MUL    = 3'd0;
    localparam logic [OP_W-1:0] MDU_MULH   = 3'd1;
    localparam logic [OP_W-1:0] MDU_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] MDU_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] MDU_DIV    = 3'd4;
    localparam logic [OP_W-1:0] MDU_DIVU   = 3'd5;
    localparam logic [OP_W-1:0] MDU_REM    = 3'd6;
    localparam logic [OP_W-1:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_signed_a(input logic [OP_W-1:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_is_signed_b(input logic [OP_W-1:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Optional MDU_EARLY_OUT_EN: zero operands skip the iteration phase.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned PW = 2 * WIDTH;

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] opd_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             neg_q, sa_q, bz_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem;
    logic             div_qbit;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [PW-1:0]    prod, prod_s;
    logic [WIDTH-1:0] quo, remd;
    logic [WIDTH-1:0] final_res;
    logic             last_step;

    // Operand sign flags and magnitudes at accept time
    always_comb begin
        sa    = op_is_signed_a(op) & a[WIDTH-1];
        sb    = op_is_signed_b(op) & b[WIDTH-1];
        mag_a = sa ? (~a + WIDTH'(1)) : a;
        mag_b = sb ? (~b + WIDTH'(1)) : b;
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (hi_q),
        .dvd_bit  (lo_q[WIDTH-1]),
        .divisor  (opd_q),
        .rem_next (div_rem),
        .q_bit    (div_qbit)
    );

    // Shared hi/lo datapath: product accumulator or remainder/quotient
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        if (op_is_div(op_q)) begin
            hi_n = div_rem;
            lo_n = {lo_q[WIDTH-2:0], div_qbit};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override on the final step's values
    always_comb begin
        prod      = {hi_n, lo_n};
        prod_s    = neg_q ? (~prod + PW'(1)) : prod;
        quo       = neg_q ? (~lo_n + WIDTH'(1)) : lo_n;
        remd      = sa_q ? (~hi_n + WIDTH'(1)) : hi_n;
        final_res = '0;
        case (op_q)
            MDU_MUL:                         final_res = prod_s[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod_s[PW-1:WIDTH];
            MDU_DIV, MDU_DIVU:               final_res = bz_q ? '1 : quo;
            default:                         final_res = bz_q ? a_q : remd;
        endcase
    end

`ifdef MDU_EARLY_OUT_EN
    logic             early;
    logic [WIDTH-1:0] early_res;

    // A zero operand gives a product/quotient/remainder of zero unless b==0 on a divide
    always_comb begin
        early     = (a == '0) || (b == '0);
        early_res = '0;
        if (op_is_div(op_q) && bz_q)
            early_res = op_q[1] ? a_q : '1;
    end
`endif

    assign last_step = (state_q == CALC) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef MDU_EARLY_OUT_EN
                if (start) state_d = early ? FIN : CALC;
`else
                if (start) state_d = CALC;
`endif
            end
            CALC: if (cnt_q == '0) state_d = FIN;
            FIN: begin
`ifdef MDU_EARLY_OUT_EN
                // Early-out entry spends one FIN cycle writing the result
                if (done_q) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            opd_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
            bz_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start && !flush) begin
                op_q  <= op;
                a_q   <= a;
                neg_q <= sa ^ sb;
                sa_q  <= sa;
                bz_q  <= (b == '0);
                cnt_q <= CNT_W'(WIDTH - 1);
                hi_q  <= '0;
                lo_q  <= op_is_div(op) ? mag_a : mag_b;
                opd_q <= op_is_div(op) ? mag_b : mag_a;
            end
        end else if (state_q == CALC) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Registered handshake and result; flush suppresses completion
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= 1'b0;
            if (last_step && !flush) begin
                result_q <= final_res;
                done_q   <= 1'b1;
            end
`ifdef MDU_EARLY_OUT_EN
            if ((state_q == FIN) && !done_q && !flush) begin
                result_q <= early_res;
                done_q   <= 1'b1;
            end
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): expected results are queued
// at issue time and popped when done pulses.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    function automatic logic [W-1:0] ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, pu;
        logic [W-1:0]    r;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        r  = '0;
        case (o)
            MDU_MUL:    r = x * y;
            MDU_MULH:   begin p = sx * sy;            r = p[63:32];  end
            MDU_MULHSU: begin p = sx * longint'(uy);  r = p[63:32];  end
            MDU_MULHU:  begin pu = ux * uy;           r = pu[63:32]; end
            MDU_DIV:    r = (y == '0) ? '1 : ((x == 32'h8000_0000 && y == '1) ? x : 32'(sx / sy));
            MDU_REM:    r = (y == '0) ? x  : ((x == 32'h8000_0000 && y == '1) ? '0 : 32'(sx % sy));
            MDU_DIVU:   r = (y == '0) ? '1 : x / y;
            default:    r = (y == '0) ? x  : x % y;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one accept; optionally queue the expected result
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e, input bit push);
        op = o; a = x; b = y; start = 1'b1;
        if (push) exp_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Cycle count starts at 1 (first cycle after accept)
    task automatic wait_done(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 1;
        while (cyc < 200) begin
            if (done) begin
                seen = 1'b1;
                return;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b want=1", zero); end
        last_res = '0;
    endtask

    task automatic test_mul_timing();
        logic [W-1:0] e;
        issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        for (int c = 1; c <= int'(W) + 2; c++) begin
            checks++;
            if (busy !== (c <= int'(W) + 1)) begin
                errors++; $display("FAIL mul_busy cycle=%0d got=%b want=%b", c, busy, c <= int'(W) + 1);
            end
            checks++;
            if (done !== (c == int'(W) + 1)) begin
                errors++; $display("FAIL mul_done cycle=%0d got=%b want=%b", c, done, c == int'(W) + 1);
            end
            if (done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_res = e;
                checks++;
                if (result !== e) begin errors++; $display("FAIL mul_result got=%h want=%h", result, e); end
            end
            tick();
        end
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] e;
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        bit           seen;
        int           cyc;
        int           exp_cyc;
        logic [W-1:0] e;
        exp_cyc = int'(W) + 1;
`ifdef MDU_EARLY_OUT_EN
        if (v.x == '0 || v.y == '0) exp_cyc = 2;
`endif
        issue(v.o, v.x, v.y, v.e, 1'b1);
        wait_done(seen, cyc);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s_timeout got=no_done want=done", name);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        last_res = e;
        if (result !== e) begin errors++; $display("FAIL %s_result got=%h want=%h", name, result, e); end
        checks++;
        if (cyc != exp_cyc) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, exp_cyc); end
        checks++;
        if (zero !== (e == '0)) begin errors++; $display("FAIL %s_zero got=%b want=%b", name, zero, e == '0); end
        tick();
    endtask

    task automatic test_ops();
        vec_t vecs[$];
        vecs.push_back('{MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{MDU_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC});
        vecs.push_back('{MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{MDU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{MDU_REMU,   32'd5,         32'd0,         32'd5});
        vecs.push_back('{MDU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1});
        vecs.push_back('{MDU_DIVU,   32'd0,         32'd9,         32'd0});
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
    endtask

    task automatic test_random();
        vec_t v;
        for (int i = 0; i < 10; i++) begin
            v.o = 3'($urandom_range(0, 7));
            v.x = $urandom;
            v.y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 1) v.y = -v.y;
            v.e = ref_model(v.o, v.x, v.y);
            run_vec(v, $sformatf("rnd%0d_op%0d", i, v.o));
        end
    endtask

    task automatic test_flush();
        bit saw_done = 1'b0;
        issue(MDU_DIVU, 32'd100, 32'd7, '0, 1'b0);
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
        // flush wins over start on the same edge
        start = 1'b1; flush = 1'b1; op = MDU_MUL; a = 32'd3; b = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%b want=0", busy); end
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done) begin errors++; $display("FAIL flush_no_done got=1 want=0"); end
        checks++; if (result !== last_res) begin errors++; $display("FAIL flush_hold got=%h want=%h", result, last_res); end
    endtask

    task automatic test_start_ignored();
        bit           seen = 1'b0;
        bit           extra = 1'b0;
        logic [W-1:0] e;
        op = MDU_MUL; a = 32'd7; b = 32'd3; start = 1'b1;
        exp_q.push_back(32'd21);
        tick();
        op = MDU_DIVU; a = 32'd1000; b = 32'd10;
        for (int c = 1; c < 100 && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL ignore_timeout got=no_done want=done");
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            last_res = e;
            if (result !== e) begin errors++; $display("FAIL ignore_result got=%h want=%h", result, e); end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got=%b want=0", busy); end
        for (int c = 0; c < 5; c++) begin
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
            tick();
        end
        checks++; if (extra) begin errors++; $display("FAIL ignore_requeue got=1 want=0"); end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        issue(MDU_MUL, 32'd3, 32'd5, '0, 1'b0);
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result got=%h want=0", result); end
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done) begin errors++; $display("FAIL rstmid_no_done got=1 want=0"); end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_ops();
        test_random();
        test_flush();
        test_start_ignored();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the pipeline CPU execute stage. It sits beside the single-cycle ALU.
- Implements the full RV32M operation set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on WIDTH-bit operands, one radix-2 step per cycle.
- Uses a start/busy/done handshake so the hazard unit can stall the pipe, and a flush input for branch/exception kill.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; accepted only when busy=0.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  WIDTH  operand A (multiplicand/dividend); sampled on accept.
- b  in  WIDTH  operand B (multiplier/divisor); sampled on accept.
- flush  in  1  abort the in-flight operation.
- busy  out  1  operation in progress; the pipe stalls while high.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered result, held until the next completion.
- zero  out  1  result == 0, combinational from the result register.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; busy=0, done=0, result=0, counter=0. Reset mid-operation discards the operation; done is not raised.
- FSM states:
  - IDLE: start=1 latches op, a, b, computes operand magnitudes and sign flags, loads counter=WIDTH-1, goes to CALC.
  - CALC: one step per cycle; leaves for FIN when counter==0, otherwise decrements the counter.
  - FIN: applies sign correction, writes result, done=1, returns to IDLE.
- Timing, with start sampled at the end of cycle 0:
  - busy=1 in cycles 1..WIDTH+1; CALC occupies cycles 1..WIDTH.
  - done=1 and result updated in cycle WIDTH+1 (33 for WIDTH=32).
  - busy=0 from cycle WIDTH+2; the earliest next accept is cycle WIDTH+2.
- start while busy=1 is ignored, including during FIN; there is no queueing.
- Multiply:
  - Shift-add on magnitudes into a 2*WIDTH product register.
  - Sign rules: MUL and MULH treat both operands as signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
  - The product is negated in FIN when the operand signs differ.
  - MUL returns product[WIDTH-1:0]; the MULH* ops return product[2W-1:W].
- Divide:
  - Restoring division on magnitudes, producing one quotient bit per cycle.
  - The quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - DIVU/REMU use raw unsigned operands.
- Division by zero (b==0), fixed outcome:
  - DIV/DIVU: all ones.
  - REM/REMU: a, unmodified.
  - The sign-fix path is bypassed.
  - Latency is unchanged unless MDU_EARLY_OUT_EN is defined.
- Signed overflow (DIV, a=MIN, b=-1): quotient = MIN, remainder = 0, with no exception flag.
- flush=1 in any state:
  - The FSM goes to IDLE at the next edge and busy=0 in the following cycle.
  - done is not raised and result keeps its old value.
  - flush has priority over FIN completion and over start on the same edge.
- rst has priority over flush, which has priority over start.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - A divide with b==0, or any op with a==0 or b==0, skips CALC and goes IDLE -> FIN.
  - done is raised in cycle 2 and busy=0 from cycle 3.
  - Results are identical to the full-latency path.
- Undefined:
  - Latency is always WIDTH+1 and the early-out logic is absent.

Decomposition:
- Shared package mdu_pkg holds:
  - op localparams: MDU_MUL ... MDU_REMU.
  - FSM state encoding: IDLE/CALC/FIN.
  - Helper predicates op_is_div and op_is_signed_a/b.
- The CPU's ALU op decode maps onto these constants.
- One natural sub-module, mdu_div_step: a combinational single restoring-division iteration taking the remainder, dividend bit and divisor, and producing the next remainder and quotient bit.
- The multiply step stays inline.

Test Plan (WIDTH=32):
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done only in cycle 33, busy cycles 1..33.
- High products:
  - MULH a=b=0xFFFFFFFF -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULHSU same operands -> 0xFFFFFFFF.
- Signed divide with negative dividend:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU same operands -> 0x7FFFFFFC.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0, zero=1.
- Division by zero:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - With MDU_EARLY_OUT_EN defined, done in cycle 2.
- Abort and reset:
  - flush in cycle 10 -> busy=0 from cycle 11, no done, result keeps its prior value.
  - start held during busy -> ignored.
  - rst mid-CALC -> busy=0, result=0 next cycle.
